odo_sbox_arbiter: RTL

- Shares one registered 6-bit Odo small-S-box lookup ROM among N requesters.
- Each requester is a round-function lane issuing single 6-bit lookups.
- Round-robin arbitration with bounded burst ownership.
- Tracks in-flight lookups through the ROM latency and returns each result to its originating requester as a one-hot response.
- Sits between the Odo round datapath lanes and a single ROM instance, so the team avoids replicating the 64-entry table per lane.

---
 rtl/odo_sbox_pkg.sv | 14 +
 rtl/odo_rr_pick.sv | 34 +++
 rtl/odo_sbox_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/odo_sbox_pkg.sv
// Shared types and helpers for the Odo small-S-box arbiter slice.
package odo_sbox_pkg;

  localparam int unsigned SBOX_W  = 6;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {IDLE, OWN} arb_state_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/odo_rr_pick.sv
// Round-robin first-set finder: lowest asserted request at or after ptr, wrapping.
module odo_rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Two ordered passes (upper half from ptr, then wrapped lower half) avoid a variable rotate.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned m = 0; m < N; m++) begin
      if (!any && req[m] && (m >= 32'(ptr))) begin
        any    = 1'b1;
        idx    = IW'(m);
        gnt[m] = 1'b1;
      end
    end
    for (int unsigned m = 0; m < N; m++) begin
      if (!any && req[m] && (m < 32'(ptr))) begin
        any    = 1'b1;
        idx    = IW'(m);
        gnt[m] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/odo_sbox_arbiter.sv
// Round-robin, burst-bounded sharing of one registered Odo 6-bit S-box ROM among N_REQ lanes.
// Optional statistics ports enabled by ODO_SBOX_ARB_STATS_EN.
module odo_sbox_arbiter
  import odo_sbox_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [SBOX_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [SBOX_W-1:0]         sbox_in,
  input  logic [SBOX_W-1:0]         sbox_out,
  output logic [N_REQ-1:0]          resp_valid,
  output logic [SBOX_W-1:0]         resp_data
`ifdef ODO_SBOX_ARB_STATS_EN
  ,
  output logic [16*N_REQ-1:0]       grant_cnt,
  output logic [7:0]                stall_max
`endif
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

  arb_state_t       state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    ptr;
  logic [3:0]       burst_cnt;

  logic [IW-1:0]    owner_inc;
  logic [IW-1:0]    pick_ptr;
  logic [MAX_REQ-1:0] owner_oh;
  logic             keep;
  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gidx;
  logic             gany;

  always_comb begin
    owner_inc = (owner == LAST) ? '0 : owner + IW'(1);
    owner_oh  = onehot(3'(owner));
    keep      = (state == OWN) && (|(owner_oh & 8'(req_valid)))
                && (burst_cnt < 4'(MAX_BURST));
    // On release or forced rotation the search starts just past the current owner.
    pick_ptr  = (state == OWN) ? owner_inc : ptr;
  end

  odo_rr_pick #(.N(N_REQ)) u_pick (
    .req (req_valid),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    gnt     = '0;
    gidx    = '0;
    gany    = 1'b0;
    sbox_in = '0;
    if (!rst) begin
      gnt  = keep ? owner_oh[N_REQ-1:0] : pick_gnt;
      gidx = keep ? owner : pick_idx;
      gany = keep || pick_any;
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt[k]) sbox_in = req_data[k*SBOX_W +: SBOX_W];
    end
    req_ready = gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else begin
      if (state == OWN && !keep) ptr <= owner_inc;
      if (gany) begin
        state     <= OWN;
        owner     <= gidx;
        burst_cnt <= keep ? burst_cnt + 4'd1 : 4'd1;
      end else begin
        state     <= IDLE;
        burst_cnt <= '0;
      end
    end
  end

  logic [ROM_LAT-1:0] sr_v;
  logic [N_REQ-1:0]   sr_tag [ROM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_v       <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      for (int unsigned k = 0; k < ROM_LAT; k++) sr_tag[k] <= '0;
    end else begin
      sr_v[0]   <= gany;
      sr_tag[0] <= gnt;
      for (int unsigned k = 1; k < ROM_LAT; k++) begin
        sr_v[k]   <= sr_v[k-1];
        sr_tag[k] <= sr_tag[k-1];
      end
      resp_valid <= sr_v[ROM_LAT-1] ? sr_tag[ROM_LAT-1] : '0;
      resp_data  <= sr_v[ROM_LAT-1] ? sbox_out : '0;
    end
  end

`ifdef ODO_SBOX_ARB_STATS_EN
  logic [7:0] stall_cnt [N_REQ];
  logic [7:0] stall_nxt [N_REQ];
  logic [7:0] smax_nxt;

  always_comb begin
    smax_nxt = stall_max;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (req_valid[k] && !gnt[k])
        stall_nxt[k] = (stall_cnt[k] == 8'hFF) ? 8'hFF : stall_cnt[k] + 8'd1;
      else
        stall_nxt[k] = '0;
      if (stall_nxt[k] > smax_nxt) smax_nxt = stall_nxt[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_max <= '0;
      for (int unsigned k = 0; k < N_REQ; k++) stall_cnt[k] <= '0;
    end else begin
      stall_max <= smax_nxt;
      for (int unsigned k = 0; k < N_REQ; k++) begin
        stall_cnt[k] <= stall_nxt[k];
        if (gnt[k] && grant_cnt[16*k +: 16] != 16'hFFFF)
          grant_cnt[16*k +: 16] <= grant_cnt[16*k +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
